// File: rtl/regfile_bank.sv
// 2-read/1-write register bank with valid bits, write handshake/ack,
// optional write-to-read bypass, optional hard-wired zero register and a sequential clear engine.
module regfile_bank #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int REG_COUNT  = 4,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic                  rd_valid1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  rd_valid2,
  output logic                  busy
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   cnt_reg;
  logic [REG_COUNT-1:0]    valid_reg;
  logic                    wr_ack_reg;
  logic                    busy_reg;
  logic [DATA_WIDTH-1:0]   mem [REG_COUNT];
  logic                    accept;
  logic                    zero_target;

  // A pending clear request wins over a simultaneous write.
  assign wr_ready    = (state_reg == S_RUN) && !clr_req;
  assign accept      = wr_valid && wr_ready;
  assign zero_target = ZERO_REG && (wr_addr == '0);
  assign wr_ack      = wr_ack_reg;
  assign busy        = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_CLEAR;
      cnt_reg    <= '0;
      valid_reg  <= '0;
      wr_ack_reg <= 1'b0;
      busy_reg   <= 1'b1;
    end else begin
      wr_ack_reg <= accept;
      case (state_reg)
        S_CLEAR: begin
          if (cnt_reg == LAST_IDX) begin
            state_reg <= S_RUN;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (clr_req) begin
            state_reg <= S_CLEAR;
            cnt_reg   <= '0;
            valid_reg <= '0;
            busy_reg  <= 1'b1;
          end else if (accept) begin
            valid_reg[wr_addr] <= 1'b1;
          end
        end
      endcase
    end
  end

  // Data storage has no reset; the clear engine zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    if (state_reg == S_CLEAR) begin
      mem[cnt_reg] <= '0;
    end else if (accept && !zero_target) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic                  vld;

      assign addr = (gi == 0) ? rd_addr1 : rd_addr2;

      // Zero register overrides everything, even the clear mask.
      always_comb begin
        data = mem[addr];
        vld  = valid_reg[addr];
        if (ZERO_REG && (addr == '0)) begin
          data = '0;
          vld  = 1'b1;
        end else if (busy_reg) begin
          data = '0;
          vld  = 1'b0;
        end else if (BYPASS && accept && (wr_addr == addr)) begin
          data = wr_data;
          vld  = 1'b1;
        end
      end
    end
  endgenerate

  assign rd_data1  = g_rd[0].data;
  assign rd_valid1 = g_rd[0].vld;
  assign rd_data2  = g_rd[1].data;
  assign rd_valid2 = g_rd[1].vld;

endmodule
